ifetch_ctrl: RTL

- Sequences the 32-word combinational instruction memory for the pipelined CPU.
- Boot phase: streams a program into the memory's write port.
- Run phase: owns the PC, drives the memory read address and fills the IF/ID pipeline register.
- Handles stall, branch redirect/flush and end-of-program halt.

---
 rtl/ifetch_pkg.sv | 10 +
 rtl/ifetch_ctrl_if.sv | 29 ++
 rtl/imem_loader.sv | 53 +++++
 rtl/ifetch_ctrl.sv | 85 ++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encodings and constants for the instruction-fetch controller
package ifetch_pkg;
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;
   localparam logic [31:0] NOP_INSTR = 32'd0;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: boot-load, instruction-memory and pipeline signals of the fetch controller
interface ifetch_ctrl_if #(parameter int AW = 5);
   logic          load_valid_i;
   logic [31:0]   load_data_i;
   logic          load_done_i;
   logic          imem_we_o;
   logic [AW-1:0] imem_waddr_o;
   logic [31:0]   imem_wdata_o;
   logic [31:0]   pc_o;
   logic [31:0]   instr_i;
   logic          stall_i;
   logic          branch_i;
   logic [31:0]   branch_target_i;
   logic          ifid_valid_o;
   logic [31:0]   ifid_instr_o;
   logic [31:0]   ifid_pc4_o;
   logic [1:0]    state_o;
   logic          load_err_o;
   modport ctrl (
      input  load_valid_i, load_data_i, load_done_i, instr_i, stall_i, branch_i, branch_target_i,
      output imem_we_o, imem_waddr_o, imem_wdata_o, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o,
             state_o, load_err_o
   );
   modport env (
      output load_valid_i, load_data_i, load_done_i, instr_i, stall_i, branch_i, branch_target_i,
      input  imem_we_o, imem_waddr_o, imem_wdata_o, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o,
             state_o, load_err_o
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-phase word counter, registered memory write port and sticky overflow flag
module imem_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          active_i,
   input  logic          load_valid_i,
   input  logic [31:0]   load_data_i,
   input  logic          load_done_i,
   output logic          we_o,
   output logic [AW-1:0] waddr_o,
   output logic [31:0]   wdata_o,
   output logic          err_o,
   output logic          done_o
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [AW:0]   cnt_q, cnt_d;
   logic          we_q, we_d, err_q, err_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          accept, room;
   assign accept = active_i && load_valid_i;
   assign room   = cnt_q < FULL;
   always_comb begin
      we_d    = accept && room;
      cnt_d   = we_d ? cnt_q + 1'b1 : cnt_q;
      waddr_d = we_d ? cnt_q[AW-1:0] : waddr_q;
      wdata_d = we_d ? load_data_i : wdata_q;
      err_d   = err_q || (accept && !room);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end
   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign err_o   = err_q;
   assign done_o  = active_i && load_done_i;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: boots the instruction memory, then owns the PC and fills the IF/ID register
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 32,
   parameter int          AW       = 5,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input logic           clk_i,
   input logic           rst_i,
   ifetch_ctrl_if.ctrl   bus
);
   localparam logic [31:0] STEP     = 32'(WORD_BYTES);
   localparam logic [31:0] LAST_PC  = 32'(WORD_BYTES * (DEPTH - 1));
   localparam logic [31:0] PC_LIMIT = 32'(WORD_BYTES * DEPTH);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, tgt;
   logic        valid_q, valid_d, in_load, load_done;
   assign in_load = state_q == ST_LOAD;
   assign tgt     = bus.branch_target_i & ~32'd3;
   imem_loader #(.DEPTH(DEPTH), .AW(AW)) u_loader (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .active_i     (in_load),
      .load_valid_i (bus.load_valid_i),
      .load_data_i  (bus.load_data_i),
      .load_done_i  (bus.load_done_i),
      .we_o         (bus.imem_we_o),
      .waddr_o      (bus.imem_waddr_o),
      .wdata_o      (bus.imem_wdata_o),
      .err_o        (bus.load_err_o),
      .done_o       (load_done)
   );
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      case (state_q)
         ST_LOAD: begin
            pc_d    = RESET_PC;
            valid_d = 1'b0;
            state_d = load_done ? ST_RUN : ST_LOAD;
         end
         ST_RUN: begin
            // branch beats stall; a target past the memory ends the program
            if (bus.branch_i) begin
               pc_d    = tgt;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               pc4_d   = '0;
               state_d = tgt >= PC_LIMIT ? ST_HALT : ST_RUN;
            end else if (!bus.stall_i) begin
               valid_d = 1'b1;
               instr_d = bus.instr_i;
               pc4_d   = pc_q + STEP;
               pc_d    = pc_q == LAST_PC ? pc_q : pc_q + STEP;
               state_d = pc_q == LAST_PC ? ST_HALT : ST_RUN;
            end
         end
         default: valid_d = 1'b0;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_LOAD;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end
   assign bus.pc_o         = pc_q;
   assign bus.state_o      = state_q;
   assign bus.ifid_valid_o = valid_q;
   assign bus.ifid_instr_o = instr_q;
   assign bus.ifid_pc4_o   = pc4_q;
endmodule
